// File: rtl/video_pattern_gen_if.sv
// Video output bus from the pattern generator to the TMDS encoder:
// syncs, data enable, pixel data and the frame marker.
interface video_pattern_gen_if #(
    parameter int COMP_WIDTH = 8
);
    logic                    hsync;
    logic                    vsync;
    logic                    de;
    logic [3*COMP_WIDTH-1:0] data;
    logic                    frame_start;

    modport master (output hsync, vsync, de, data, frame_start);
    modport slave  (input  hsync, vsync, de, data, frame_start);
endinterface

// File: rtl/video_pattern_gen.sv
// Parametrised DVI/VGA timing generator with selectable test patterns,
// frame-aligned run/stop and frame-aligned pattern switching.
module video_pattern_gen #(
    parameter int   COMP_WIDTH   = 8,
    parameter int   CNT_WIDTH    = 12,
    parameter logic H_POL        = 1'b0,
    parameter int   H_PULSE      = 96,
    parameter int   H_BACKPORCH  = 48,
    parameter int   H_VISIBLE    = 640,
    parameter int   H_FRONTPORCH = 16,
    parameter logic V_POL        = 1'b0,
    parameter int   V_PULSE      = 2,
    parameter int   V_BACKPORCH  = 33,
    parameter int   V_VISIBLE    = 480,
    parameter int   V_FRONTPORCH = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [2:0]              pattern_sel,
    input  logic [3*COMP_WIDTH-1:0] solid_color,
    video_pattern_gen_if.master     vid,
    output logic                    running,
    output logic [15:0]             frame_count
);
    localparam int DW       = 3 * COMP_WIDTH;
    localparam int BOX_SIZE = 32;

    localparam logic [CNT_WIDTH-1:0] H_LAST      = CNT_WIDTH'(H_PULSE + H_BACKPORCH + H_VISIBLE + H_FRONTPORCH - 1);
    localparam logic [CNT_WIDTH-1:0] V_LAST      = CNT_WIDTH'(V_PULSE + V_BACKPORCH + V_VISIBLE + V_FRONTPORCH - 1);
    localparam logic [CNT_WIDTH-1:0] H_SYNC_END  = CNT_WIDTH'(H_PULSE);
    localparam logic [CNT_WIDTH-1:0] V_SYNC_END  = CNT_WIDTH'(V_PULSE);
    localparam logic [CNT_WIDTH-1:0] H_ACT_START = CNT_WIDTH'(H_PULSE + H_BACKPORCH);
    localparam logic [CNT_WIDTH-1:0] V_ACT_START = CNT_WIDTH'(V_PULSE + V_BACKPORCH);
    localparam logic [CNT_WIDTH-1:0] H_ACT_END   = CNT_WIDTH'(H_PULSE + H_BACKPORCH + H_VISIBLE);
    localparam logic [CNT_WIDTH-1:0] V_ACT_END   = CNT_WIDTH'(V_PULSE + V_BACKPORCH + V_VISIBLE);
    localparam logic [CNT_WIDTH-1:0] BAR_LAST    = CNT_WIDTH'(H_VISIBLE / 8 - 1);
    localparam logic [CNT_WIDTH-1:0] BOX_W       = CNT_WIDTH'(BOX_SIZE);
    localparam logic [CNT_WIDTH-1:0] BOX_X_LAST  = CNT_WIDTH'(H_VISIBLE - BOX_SIZE - 1);
    localparam logic [DW-1:0]        ALL_ONES    = {DW{1'b1}};

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   h_q, h_d;
    logic [CNT_WIDTH-1:0]   v_q, v_d;
    logic [2:0]             pat_q, pat_d;
    logic [CNT_WIDTH-1:0]   box_x_q, box_x_d;
    logic [CNT_WIDTH-1:0]   bar_px_q, bar_px_d;
    logic [2:0]             bar_idx_q, bar_idx_d;
    logic [15:0]            frame_count_q, frame_count_d;
    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic                   de_q, de_d;
    logic [DW-1:0]          data_q, data_d;
    logic                   frame_start_q, frame_start_d;
    logic                   running_q, running_d;

    logic                   is_run;
    logic                   frame_first;
    logic                   frame_last;
    logic [CNT_WIDTH-1:0]   x;
    logic [CNT_WIDTH-1:0]   y;
    logic                   active;
    logic [2:0]             pat_cur;
    logic [COMP_WIDTH-1:0]  grad;
    logic [DW-1:0]          pixel;

    assign is_run      = (state_q == ST_RUN);
    assign frame_first = (h_q == '0) && (v_q == '0);
    assign frame_last  = (h_q == H_LAST) && (v_q == V_LAST);

    // Run/stop state; stopping is only allowed on the last pixel so frames are never cut short
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable)                state_d = ST_RUN;
            ST_RUN:  if (frame_last && !enable) state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // Raster counters and per-frame bookkeeping; counters sit at 0,0 whenever idle
    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        pat_d         = pat_q;
        box_x_d       = box_x_q;
        frame_count_d = frame_count_q;
        if (is_run) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
            if (frame_first) begin
                pat_d = pattern_sel;
            end
            if (frame_last) begin
                frame_count_d = frame_count_q + 16'd1;
                box_x_d       = (box_x_q == BOX_X_LAST) ? '0 : box_x_q + 1'b1;
            end
        end

        // Bar index tracks x by counting pixels within each bar, avoiding a divider
        if (h_d == H_ACT_START) begin
            bar_px_d  = '0;
            bar_idx_d = '0;
        end else if (bar_px_q == BAR_LAST) begin
            bar_px_d  = '0;
            bar_idx_d = bar_idx_q + 3'd1;
        end else begin
            bar_px_d  = bar_px_q + 1'b1;
            bar_idx_d = bar_idx_q;
        end
    end

    // Output decode; the select is taken live on the first pixel so a new frame starts on the new pattern
    always_comb begin
        x       = h_q - H_ACT_START;
        y       = v_q - V_ACT_START;
        active  = (h_q >= H_ACT_START) && (h_q < H_ACT_END) &&
                  (v_q >= V_ACT_START) && (v_q < V_ACT_END);
        pat_cur = frame_first ? pattern_sel : pat_q;
        grad    = COMP_WIDTH'(x);
        pixel   = '0;
        case (pat_cur)
            3'd0: pixel = {grad & {COMP_WIDTH{~y[8]}},
                           grad & {COMP_WIDTH{~y[7]}},
                           grad & {COMP_WIDTH{~y[6]}}};
            3'd1: pixel = {{COMP_WIDTH{~bar_idx_q[1]}},
                           {COMP_WIDTH{~bar_idx_q[2]}},
                           {COMP_WIDTH{~bar_idx_q[0]}}};
            3'd2: pixel = (x[4] ^ y[4]) ? ALL_ONES : '0;
            3'd3: pixel = solid_color;
            3'd4: if ((y < BOX_W) && (x >= box_x_q) && (x < box_x_q + BOX_W)) pixel = solid_color;
            default: pixel = '0;
        endcase

        hsync_d       = ~H_POL;
        vsync_d       = ~V_POL;
        de_d          = 1'b0;
        data_d        = '0;
        frame_start_d = 1'b0;
        running_d     = 1'b0;
        if (is_run) begin
            hsync_d       = (h_q < H_SYNC_END) ? H_POL : ~H_POL;
            vsync_d       = (v_q < V_SYNC_END) ? V_POL : ~V_POL;
            de_d          = active;
            data_d        = active ? pixel : '0;
            frame_start_d = frame_first;
            running_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q           <= '0;
            v_q           <= '0;
            pat_q         <= '0;
            box_x_q       <= '0;
            bar_px_q      <= '0;
            bar_idx_q     <= '0;
            frame_count_q <= '0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            de_q          <= 1'b0;
            data_q        <= '0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            pat_q         <= pat_d;
            box_x_q       <= box_x_d;
            bar_px_q      <= bar_px_d;
            bar_idx_q     <= bar_idx_d;
            frame_count_q <= frame_count_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            data_q        <= data_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
        end
    end

    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.data        = data_q;
    assign vid.frame_start = frame_start_q;
    assign running         = running_q;
    assign frame_count     = frame_count_q;
endmodule
